// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: six-state FSM executing one instruction at a time over
// request/acknowledge instruction and data memory handshakes.
module multicycle_cpu #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned REG_NUM         = 32,
    parameter int unsigned INSN_ADDR_WIDTH = 16,
    parameter int unsigned DATA_ADDR_WIDTH = 16,
    parameter int unsigned RESET_PC        = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [INSN_ADDR_WIDTH-1:0] insnAddr,
    output logic                       insnReq,
    input  logic                       insnValid,
    input  logic [31:0]                insn,
    output logic [DATA_ADDR_WIDTH-1:0] dataAddr,
    output logic [DATA_WIDTH-1:0]      dataOut,
    output logic                       dataWrEnable,
    output logic                       dataReq,
    input  logic                       dataAck,
    input  logic [DATA_WIDTH-1:0]      dataIn,
    output logic                       halted,
    output logic [31:0]                retireCount
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LD   = 6'h23;
    localparam logic [5:0] OP_ST   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;

    localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
    } state_t;

    state_t                       r_state, w_state_next;
    logic [31:0]                  r_insn;
    logic [DATA_WIDTH-1:0]        r_rs_val, r_rt_val, r_result;
    logic [DATA_WIDTH-1:0]        r_regs [REG_NUM];
    logic [INSN_ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_ADDR_WIDTH-1:0]   r_data_addr;
    logic [DATA_WIDTH-1:0]        r_data_out;
    logic [31:0]                  r_retire;

    logic [5:0]                   w_op, w_funct;
    logic [4:0]                   w_rs, w_rt, w_rd, w_shamt, w_dest;
    logic [15:0]                  w_const;
    logic                         w_legal, w_is_ld, w_is_st, w_is_br, w_taken;
    logic [DATA_WIDTH-1:0]        w_rs_rd, w_rt_rd, w_sext, w_zext, w_alu;
    logic [INSN_ADDR_WIDTH-1:0]   w_pc_inc, w_br_off;

    assign w_op     = r_insn[31:26];
    assign w_rs     = r_insn[25:21];
    assign w_rt     = r_insn[20:16];
    assign w_rd     = r_insn[15:11];
    assign w_shamt  = r_insn[10:6];
    assign w_funct  = r_insn[5:0];
    assign w_const  = r_insn[15:0];

    assign w_is_ld  = (w_op == OP_LD);
    assign w_is_st  = (w_op == OP_ST);
    assign w_is_br  = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_taken  = (w_op == OP_BEQ) ? (r_rs_val == r_rt_val) : (r_rs_val != r_rt_val);
    assign w_pc_inc = r_pc + INSN_ADDR_WIDTH'(1);
    assign w_br_off = INSN_ADDR_WIDTH'({{16{w_const[15]}}, w_const});
    // Three-operand ALU ops write rd; shifts, immediates and loads write rs.
    assign w_dest   = (w_op == OP_R && w_funct != F_SLL && w_funct != F_SRL) ? w_rd : w_rs;

    always_comb begin
        w_sext        = {DATA_WIDTH{w_const[15]}};
        w_sext[15:0]  = w_const;
        w_zext        = '0;
        w_zext[15:0]  = w_const;
    end

    // Unimplemented registers and r0 read as zero.
    always_comb begin
        w_rs_rd = '0;
        w_rt_rd = '0;
        if (w_rs != 5'd0 && 32'(w_rs) < REG_NUM) w_rs_rd = r_regs[w_rs[IDX_W-1:0]];
        if (w_rt != 5'd0 && 32'(w_rt) < REG_NUM) w_rt_rd = r_regs[w_rt[IDX_W-1:0]];
    end

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL: w_legal = 1'b1;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LD, OP_ST, OP_BEQ, OP_BNE: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_R: begin
                case (w_funct)
                    F_ADD: w_alu = r_rs_val + r_rt_val;
                    F_SUB: w_alu = r_rs_val - r_rt_val;
                    F_AND: w_alu = r_rs_val & r_rt_val;
                    F_OR:  w_alu = r_rs_val | r_rt_val;
                    F_SLT: w_alu = DATA_WIDTH'($signed(r_rs_val) < $signed(r_rt_val));
                    F_SLL: w_alu = (32'(w_shamt) >= DATA_WIDTH) ? '0 : (r_rt_val << w_shamt);
                    F_SRL: w_alu = (32'(w_shamt) >= DATA_WIDTH) ? '0 : (r_rt_val >> w_shamt);
                    default: w_alu = '0;
                endcase
            end
            OP_ADDI: w_alu = r_rt_val + w_sext;
            OP_ANDI: w_alu = r_rt_val & w_zext;
            OP_ORI:  w_alu = r_rt_val | w_zext;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= StFetch;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StFetch:     if (insnValid) w_state_next = StDecode;
            StDecode:    w_state_next = w_legal ? StExecute : StHalt;
            StExecute: begin
                if (w_is_br)                  w_state_next = StFetch;
                else if (w_is_ld || w_is_st)  w_state_next = StMem;
                else                          w_state_next = StWriteback;
            end
            StMem:       if (dataAck) w_state_next = w_is_ld ? StWriteback : StFetch;
            StWriteback: w_state_next = StFetch;
            StHalt:      w_state_next = StHalt;
            default:     w_state_next = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_insn      <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_result    <= '0;
            r_pc        <= INSN_ADDR_WIDTH'(RESET_PC);
            r_data_addr <= '0;
            r_data_out  <= '0;
            r_retire    <= '0;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                StFetch: if (insnValid) r_insn <= insn;
                StDecode: begin
                    r_rs_val <= w_rs_rd;
                    r_rt_val <= w_rt_rd;
                end
                StExecute: begin
                    if (w_is_br) begin
                        r_pc     <= w_taken ? (w_pc_inc + w_br_off) : w_pc_inc;
                        r_retire <= r_retire + 32'd1;
                    end else if (w_is_ld || w_is_st) begin
                        r_data_addr <= DATA_ADDR_WIDTH'(r_rt_val + w_sext);
                        r_data_out  <= r_rs_val;
                    end else begin
                        r_result <= w_alu;
                    end
                end
                StMem: begin
                    if (dataAck) begin
                        if (w_is_ld) begin
                            r_result <= dataIn;
                        end else begin
                            r_pc     <= w_pc_inc;
                            r_retire <= r_retire + 32'd1;
                        end
                    end
                end
                StWriteback: begin
                    if (w_dest != 5'd0 && 32'(w_dest) < REG_NUM)
                        r_regs[w_dest[IDX_W-1:0]] <= r_result;
                    r_pc     <= w_pc_inc;
                    r_retire <= r_retire + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Gated with rst so no fetch is requested while reset is held.
    assign insnReq      = (r_state == StFetch) && rst;
    assign dataReq      = (r_state == StMem);
    assign dataWrEnable = (r_state == StMem) && w_is_st;
    assign halted       = (r_state == StHalt);
    assign insnAddr     = r_pc;
    assign dataAddr     = r_data_addr;
    assign dataOut      = r_data_out;
    assign retireCount  = r_retire;

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle CPU core: a six-state FSM (fetch, decode, execute, memory, write-back, halt) that runs the existing instruction set over request/acknowledge handshakes to instruction and data memory, so both may insert wait states. Data width, register count, address widths and reset PC are parameters. It adds a retired-instruction counter and a halt state for illegal opcodes. It drops in at the top level in place of `CPU`, between the instruction ROM and the data bus.

## Interface
- DATA_WIDTH, 32: register/ALU/data-bus width (16..32)
- REG_NUM, 32: implemented registers (2..32); r0 reads 0
- INSN_ADDR_WIDTH, 16: insnAddr width (word address)
- DATA_ADDR_WIDTH, 16: dataAddr width (word address)
- RESET_PC, 0: PC after reset

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- insnAddr  out  INSN_ADDR_WIDTH  fetch address (= PC)
- insnReq  out  1  fetch request
- insnValid  in  1  insn valid this cycle
- insn  in  32  instruction word
- dataAddr  out  DATA_ADDR_WIDTH  load/store address
- dataOut  out  DATA_WIDTH  store data
- dataWrEnable  out  1  1 = store, 0 = load (valid with dataReq)
- dataReq  out  1  data access request
- dataAck  in  1  access complete; load data valid on dataIn
- dataIn  in  DATA_WIDTH  load data
- halted  out  1  core in HALT
- retireCount  out  32  retired instructions, wraps at 2^32

## Operation
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], constant[15:0]. Opcodes and functs are the `OP_CODE_*` / `FUNCT_CODE_*` encodings in Types.v.
- Register indices >= REG_NUM and r0 read 0. Writes to them are dropped.
- ALU ops (rd <= f(rs, rt)): ADD, SUB, AND, OR, SLT (signed, result 0/1). SLL and SRL are rs <= rt shifted by shamt; SRL is logical. If shamt >= DATA_WIDTH the result is 0.
- ADDI: rs <= rt + sext(constant). ANDI / ORI: rs <= rt & / | zext(constant).
- LD: rs <= mem[rt + sext(constant)]. ST: mem[rt + sext(constant)] <= rs. The address is the low DATA_ADDR_WIDTH bits of the DATA_WIDTH sum. Arithmetic wraps mod 2^DATA_WIDTH.
- BEQ / BNE compare rs and rt. Taken: PC <= PC + 1 + sext(constant), truncated to INSN_ADDR_WIDTH. Not taken: PC <= PC + 1. All other instructions set PC <= PC + 1; the PC wraps.
- FSM transitions:
  - FETCH: insnReq=1. On insnValid, latch insn and go to DECODE; otherwise stay.
  - DECODE: read rs and rt into operand latches. An unknown op or funct goes to HALT.
  - EXECUTE: ALU/imm go to WRITEBACK. LD/ST latch address and data, then go to MEM. A branch updates PC, retires, and goes to FETCH.
  - MEM: dataReq held with stable addr/data/WrEnable until dataAck. LD latches dataIn and goes to WRITEBACK. ST sets PC+1, retires, and goes to FETCH.
  - WRITEBACK: register write, PC+1, retire, go to FETCH.
  - HALT: absorbing (left only by reset). halted=1, no requests.
- retireCount increments once per completed instruction.

## Timing
- Reset (rst=0, async): state FETCH, PC=RESET_PC, all registers 0, retireCount 0. insnReq, dataReq, dataWrEnable and halted are 0; dataAddr and dataOut are 0. insnReq rises the first cycle after rst deasserts.
- Reset mid-access aborts the request. A late dataAck or insnValid is ignored.
- Cycles per instruction with zero-wait memory (insnValid in first FETCH cycle, dataAck in first MEM cycle): ALU/imm 4, LD 5, ST 4, branch 3. Each wait cycle adds 1.
- insnValid is sampled only in FETCH and dataAck only in MEM. Both are ignored elsewhere.
- The register write in WRITEBACK is visible to the next instruction's DECODE (no hazard; the core is not pipelined).

## Test plan
- Reset then ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2 with zero-wait memory -> r3=12, retireCount=3 after 12 cycles, insnAddr=3.
- ST r3 -> [r0+4] with dataAck delayed 3 cycles -> dataReq high 4 cycles, dataAddr=4, dataOut=12, dataWrEnable=1 stable throughout. LD r4 <- [4] returns 12.
- BEQ r1,r1,-1 at PC=10 -> PC=10 again, 3 cycles/iteration. BNE r1,r1,+5 -> PC=11.
- DATA_WIDTH=16: ADDI r1,r0,0x7FFF then ADDI r1,r1,1 -> 0x8000; SLT r2,r1,r0 -> 1; SLL by shamt=20 -> 0.
- REG_NUM=8: ADDI r9,r0,3 is dropped, reads of r9 return 0. Illegal opcode -> halted=1, insnReq=0, retireCount frozen.
- Assert rst during a MEM wait, then give dataAck -> PC=RESET_PC, no register written, dataReq=0.
